// File: rtl/uart_tx_result_fifo.sv
// Result byte queue feeding uart_tx: buffers up to 2**ADDR_BITS bytes and sequences
// them out over the tx_start / tx_done_tick handshake.
module uart_tx_result_fifo #(
    parameter int unsigned NB_BITS   = 8,
    parameter int unsigned ADDR_BITS = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NB_BITS-1:0]   i_data,
    input  logic                 i_push,
    input  logic                 i_tx_done,
    output logic                 o_tx_start,
    output logic [NB_BITS-1:0]   o_tx_data,
    output logic                 o_full,
    output logic                 o_empty,
    output logic [ADDR_BITS:0]   o_count,
    output logic                 o_overflow
);

    localparam int unsigned           Depth    = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0]    DepthCnt = (ADDR_BITS+1)'(Depth);

    typedef enum logic [1:0] {StIdle, StStart, StWait} state_e;

    state_e                 state_q, state_d;
    logic [NB_BITS-1:0]     mem [Depth];
    logic [ADDR_BITS-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_BITS:0]     count_q, count_d;
    logic [NB_BITS-1:0]     tx_data_q, tx_data_d;
    logic                   overflow_q, overflow_d;
    logic                   full, push_ok, pop;

    assign full    = (count_q == DepthCnt);
    // Full is taken from the registered count, so a same-cycle pop never frees a slot.
    assign push_ok = i_push && !full;
    assign pop     = (state_q == StWait) && i_tx_done;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (i_push & full);
        if (push_ok) wr_ptr_d = wr_ptr_q + ADDR_BITS'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + ADDR_BITS'(1);
        case ({push_ok, pop})
            2'b10:   count_d = count_q + (ADDR_BITS+1)'(1);
            2'b01:   count_d = count_q - (ADDR_BITS+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // The head byte stays counted until its frame is done; it is popped from WAIT.
    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    state_d   = StStart;
                    tx_data_d = mem[rd_ptr_q];
                end
            end
            StStart: state_d = StWait;
            StWait:  if (i_tx_done) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tx_data_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tx_data_q  <= tx_data_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push_ok) mem[wr_ptr_q] <= i_data;
    end

    assign o_tx_start = (state_q == StStart);
    assign o_tx_data  = tx_data_q;
    assign o_full     = full;
    assign o_empty    = (count_q == '0);
    assign o_count    = count_q;
    assign o_overflow = overflow_q;

endmodule
